if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of the instruction field decoder in ID.
- Holds the PC, drives the instruction-memory address, and captures the returned word, its PC and PC+4 into the IF/ID pipeline register.
- The ID-stage decoder consumes id_inst directly.
- Supports hazard stall, branch/jump redirect, flush-to-NOP, and an address-fault flag carried with the fetched word.

---
 rtl/if_stage.sv | 87 ++++++++
 tb/tb_if_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, drives the instruction-memory address and
// loads the IF/ID pipeline register with the fetched word, its PC, PC+4 and a fault flag.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        id_fault
);

  // Range bounds carried in 33 bits so a window reaching 2^32 cannot wrap.
  localparam logic [32:0] LO_BOUND = {1'b0, IMEM_BASE};
  localparam logic [32:0] HI_BOUND = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

  logic [31:0] r_pc;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic        r_id_valid;
  logic        r_id_fault;

  logic [31:0] w_pc4;
  logic [32:0] w_pc33;
  logic        w_fault;
  logic [31:0] w_fetch_word;

  always_comb begin
    w_pc4        = r_pc + 32'd4;
    w_pc33       = {1'b0, r_pc};
    w_fault      = (r_pc[1:0] != 2'b00) || (w_pc33 < LO_BOUND) || (w_pc33 >= HI_BOUND);
    w_fetch_word = w_fault ? '0 : imem_rdata;
  end

  // Stall outranks redirect: the hazard unit re-presents the redirect afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!stall) begin
      r_pc <= redirect ? redirect_pc : w_pc4;
    end
  end

  // Flush outranks stall so a stalled slot can still be turned into a NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_inst  <= '0;
      r_id_pc    <= '0;
      r_id_pc4   <= '0;
      r_id_valid <= 1'b0;
      r_id_fault <= 1'b0;
    end else if (flush) begin
      r_id_inst  <= '0;
      r_id_pc    <= r_pc;
      r_id_pc4   <= w_pc4;
      r_id_valid <= 1'b0;
      r_id_fault <= 1'b0;
    end else if (!stall) begin
      r_id_inst  <= w_fetch_word;
      r_id_pc    <= r_pc;
      r_id_pc4   <= w_pc4;
      r_id_valid <= 1'b1;
      r_id_fault <= w_fault;
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign id_inst   = r_id_inst;
  assign id_pc     = r_id_pc;
  assign id_pc4    = r_id_pc4;
  assign id_valid  = r_id_valid;
  assign id_fault  = r_id_fault;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized control
// traffic compared against a cycle-level reference model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int unsigned WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc, id_inst, id_pc, id_pc4;
  logic        id_valid, id_fault;

  logic        use_fn = 1'b1;
  logic [31:0] const_word = '0;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_pc, m_inst, m_idpc, m_idpc4;
  logic        m_valid, m_fault;

  always #5 clk = ~clk;

  // Never-zero memory contents so fault suppression is observable.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return ((a * 32'h9E37_79B1) ^ 32'h1234_5678) | 32'h1;
  endfunction

  assign imem_rdata = use_fn ? memfn(imem_addr) : const_word;

  if_stage #(
    .RESET_PC  (32'h0000_3000),
    .IMEM_BASE (BASE),
    .IMEM_WORDS(WORDS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid),
    .id_fault   (id_fault)
  );

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_inst = 0; m_idpc = 0; m_idpc4 = 0; m_valid = 0; m_fault = 0;
  endtask

  // One clock edge of the fetch stage as described by its priority rules.
  task automatic model_step();
    bit          flt;
    logic [31:0] word;
    flt  = (m_pc % 4 != 0) || (longint'(m_pc) < longint'(BASE)) ||
           (longint'(m_pc) >= longint'(BASE) + 4 * longint'(WORDS));
    word = flt ? 32'd0 : (use_fn ? memfn(m_pc) : const_word);
    if (flush) begin
      m_inst = 0; m_valid = 0; m_fault = 0; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
    end else if (!stall) begin
      m_inst = word; m_valid = 1; m_fault = flt; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
    end
    if (!stall) m_pc = redirect ? redirect_pc : m_pc + 32'd4;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (pc !== 32'h3000) $display("FAIL reset_pc got %h want 00003000", pc); else n_pass++;
    n_total++; if (id_inst !== 0) $display("FAIL reset_inst got %h want 0", id_inst); else n_pass++;
    n_total++; if ({id_pc, id_pc4} !== 64'd0) $display("FAIL reset_idpc got %h/%h want 0/0", id_pc, id_pc4); else n_pass++;
    n_total++; if ({id_valid, id_fault} !== 2'b00) $display("FAIL reset_flags got %b%b want 00", id_valid, id_fault); else n_pass++;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    do_reset();
    use_fn = 0; const_word = 32'h2408_0001;
    tick();
    n_total++; if (id_pc !== 32'h3000) $display("FAIL free_idpc got %h want 00003000", id_pc); else n_pass++;
    n_total++; if (id_pc4 !== 32'h3004) $display("FAIL free_idpc4 got %h want 00003004", id_pc4); else n_pass++;
    n_total++; if (id_inst !== 32'h2408_0001) $display("FAIL free_inst got %h want 24080001", id_inst); else n_pass++;
    n_total++; if (id_valid !== 1'b1) $display("FAIL free_valid got %b want 1", id_valid); else n_pass++;
    exp_pc = 32'h3004;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (pc !== exp_pc) $display("FAIL free_pc%0d got %h want %h", i, pc, exp_pc); else n_pass++;
      if (i < 3) tick();
      exp_pc += 4;
    end
    use_fn = 1;
  endtask

  task automatic test_stall();
    logic [31:0] s_inst, s_pc;
    do_reset();
    tick(); tick();
    s_inst = id_inst; s_pc = id_pc;
    n_total++; if (pc !== 32'h3008) $display("FAIL stall_start got %h want 00003008", pc); else n_pass++;
    stall = 1; redirect = 1; redirect_pc = 32'h3800;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (pc !== 32'h3008) $display("FAIL stall_pc%0d got %h want 00003008", i, pc); else n_pass++;
      n_total++; if ({id_inst, id_pc, id_pc4, id_valid} !== {memfn(32'h3004), 32'h3004, 32'h3008, 1'b1})
        $display("FAIL stall_ifid%0d got %h/%h/%h/%b want %h/%h", i, id_inst, id_pc, id_pc4, id_valid, s_inst, s_pc);
      else n_pass++;
    end
    stall = 0; redirect = 0;
    n_total++; if (pc !== 32'h3008) $display("FAIL stall_hold got %h want 00003008", pc); else n_pass++;
    tick();
    n_total++; if (pc !== 32'h300C) $display("FAIL stall_release got %h want 0000300c", pc); else n_pass++;
    n_total++; if (id_pc !== 32'h3008) $display("FAIL stall_release_idpc got %h want 00003008", id_pc); else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    redirect = 1; redirect_pc = 32'h3040;
    tick();
    redirect = 0;
    n_total++; if (pc !== 32'h3040) $display("FAIL redir_pc got %h want 00003040", pc); else n_pass++;
    n_total++; if (id_pc !== 32'h3010) $display("FAIL redir_slot got %h want 00003010", id_pc); else n_pass++;
    n_total++; if (id_inst !== memfn(32'h3010)) $display("FAIL redir_slot_inst got %h want %h", id_inst, memfn(32'h3010)); else n_pass++;
    tick();
    n_total++; if (id_pc !== 32'h3040) $display("FAIL redir_target got %h want 00003040", id_pc); else n_pass++;
    n_total++; if (id_inst !== memfn(32'h3040)) $display("FAIL redir_target_inst got %h want %h", id_inst, memfn(32'h3040)); else n_pass++;
  endtask

  task automatic test_flush_stall();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    flush = 1; stall = 1;
    tick();
    flush = 0; stall = 0;
    n_total++; if (id_inst !== 0) $display("FAIL fs_inst got %h want 0", id_inst); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL fs_valid got %b want 0", id_valid); else n_pass++;
    n_total++; if (pc !== 32'h3020) $display("FAIL fs_pc got %h want 00003020", pc); else n_pass++;
    tick();
    n_total++; if (id_pc !== 32'h3020) $display("FAIL fs_refetch got %h want 00003020", id_pc); else n_pass++;
    n_total++; if (id_valid !== 1'b1) $display("FAIL fs_refetch_valid got %b want 1", id_valid); else n_pass++;
    flush = 1; redirect = 1; redirect_pc = 32'h3100;
    tick();
    flush = 0; redirect = 0;
    n_total++; if ({pc, id_valid, id_inst} !== {32'h3100, 1'b0, 32'd0})
      $display("FAIL fr_squash got %h/%b/%h want 00003100/0/0", pc, id_valid, id_inst);
    else n_pass++;
  endtask

  task automatic test_fault();
    logic [31:0] tgt [5];
    logic        exp_f [5];
    tgt[0] = 32'h3002; exp_f[0] = 1;
    tgt[1] = 32'h2FFC; exp_f[1] = 1;
    tgt[2] = 32'h3000 + 4 * 4095; exp_f[2] = 0;
    tgt[3] = 32'h3000 + 4 * 4096; exp_f[3] = 1;
    tgt[4] = 32'h3000; exp_f[4] = 0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      redirect = 1; redirect_pc = tgt[k];
      tick();
      redirect = 0;
      tick();
      n_total++; if (id_fault !== exp_f[k]) $display("FAIL fault_flag[%h] got %b want %b", tgt[k], id_fault, exp_f[k]); else n_pass++;
      n_total++; if (id_pc !== tgt[k]) $display("FAIL fault_idpc got %h want %h", id_pc, tgt[k]); else n_pass++;
      n_total++; if (id_inst !== (exp_f[k] ? 32'd0 : memfn(tgt[k])))
        $display("FAIL fault_inst[%h] got %h want %h", tgt[k], id_inst, exp_f[k] ? 32'd0 : memfn(tgt[k]));
      else n_pass++;
    end
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 0;
    tick();
    n_total++; if ({pc, id_fault, id_pc4} !== {32'd0, 1'b1, 32'd0})
      $display("FAIL wrap got %h/%b/%h want 00000000/1/00000000", pc, id_fault, id_pc4);
    else n_pass++;
  endtask

  task automatic test_random();
    int kind;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 99) < 20);
      flush    = ($urandom_range(0, 99) < 15);
      redirect = ($urandom_range(0, 99) < 20);
      kind     = $urandom_range(0, 9);
      if (kind < 6)       redirect_pc = BASE + 4 * $urandom_range(0, WORDS - 1);
      else if (kind == 6) redirect_pc = BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3);
      else if (kind == 7) redirect_pc = $urandom_range(0, 32'h2FFF);
      else if (kind == 8) redirect_pc = BASE + 4 * WORDS + $urandom_range(0, 32'hFFFF);
      else                redirect_pc = BASE + 4 * WORDS - 4 * $urandom_range(0, 3);
      tick();
      n_total++; if (pc !== m_pc || imem_addr !== m_pc) $display("FAIL rnd_pc@%0d got %h/%h want %h", i, pc, imem_addr, m_pc); else n_pass++;
      n_total++; if (id_inst !== m_inst) $display("FAIL rnd_inst@%0d got %h want %h", i, id_inst, m_inst); else n_pass++;
      n_total++; if (id_pc !== m_idpc) $display("FAIL rnd_idpc@%0d got %h want %h", i, id_pc, m_idpc); else n_pass++;
      n_total++; if (id_pc4 !== m_idpc4) $display("FAIL rnd_idpc4@%0d got %h want %h", i, id_pc4, m_idpc4); else n_pass++;
      n_total++; if (id_valid !== m_valid) $display("FAIL rnd_valid@%0d got %b want %b", i, id_valid, m_valid); else n_pass++;
      n_total++; if (id_fault !== m_fault) $display("FAIL rnd_fault@%0d got %b want %b", i, id_fault, m_fault); else n_pass++;
    end
    stall = 0; flush = 0; redirect = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    stall = 1;
    tick();
    n_total++; if (pc !== 32'h3050) $display("FAIL areset_pre got %h want 00003050", pc); else n_pass++;
    #2 reset = 1;
    #1;
    n_total++; if (pc !== 32'h3000) $display("FAIL areset_pc got %h want 00003000", pc); else n_pass++;
    n_total++; if ({id_valid, id_inst} !== 33'd0) $display("FAIL areset_ifid got %b/%h want 0/0", id_valid, id_inst); else n_pass++;
    @(negedge clk);
    model_reset();
    reset = 0; stall = 0;
    tick();
    n_total++; if ({pc, id_pc, id_valid} !== {32'h3004, 32'h3000, 1'b1})
      $display("FAIL areset_first got %h/%h/%b want 00003004/00003000/1", pc, id_pc, id_valid);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_fault();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
